// File: rtl/mem_responder.sv
// Memory-side responder for the SLC-3 MAR/MDR interface: word RAM plus one
// memory-mapped I/O location, serviced after a fixed number of wait states.
module mem_responder #(
    parameter int          ADDR_BITS   = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR,
    input  logic        Mem_RD,
    input  logic        Mem_WR,
    input  logic [15:0] Switches,
    output logic [15:0] MDR_In,
    output logic        R,
    output logic [15:0] HEX_Out
);
    localparam int         RAM_DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_DONE} state_t;
    typedef enum logic [1:0] {SRC_ZERO, SRC_SW, SRC_RAM} src_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        wr_q, wr_d;
    logic [15:0] hex_q, hex_d;
    logic [15:0] sw_q, sw_d;
    src_t        src_q, src_d;

    logic [15:0] ram [RAM_DEPTH];
    logic [15:0] ram_rd_q;

    logic                 req;
    logic                 commit;
    logic [15:0]          c_addr;
    logic [15:0]          c_data;
    logic                 c_wr;
    logic                 c_is_io;
    logic                 c_is_ram;
    logic                 ram_we;
    logic                 ram_re;
    logic [ADDR_BITS-1:0] ram_idx;

    assign req = Mem_RD | Mem_WR;

    // With zero wait states the commit happens on the capture edge itself,
    // so the operands come straight from the request inputs.
    assign c_addr   = (state_q == S_IDLE) ? MAR    : addr_q;
    assign c_data   = (state_q == S_IDLE) ? MDR    : data_q;
    assign c_wr     = (state_q == S_IDLE) ? Mem_WR : wr_q;
    assign c_is_io  = (c_addr == IO_ADDR);
    assign c_is_ram = !c_is_io && ((c_addr >> ADDR_BITS) == 16'd0);
    assign ram_idx  = c_addr[ADDR_BITS-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wr_d    = wr_q;
        hex_d   = hex_q;
        sw_d    = sw_q;
        src_d   = src_q;
        commit  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d = MAR;
                    data_d = MDR;
                    wr_d   = Mem_WR;
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: state_d = S_DONE;
            S_DONE: if (!req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (commit) begin
            if (c_wr) begin
                if (c_is_io) hex_d = c_data;
            end else if (c_is_io) begin
                src_d = SRC_SW;
                sw_d  = Switches;
            end else if (c_is_ram) begin
                src_d = SRC_RAM;
            end else begin
                src_d = SRC_ZERO;
            end
        end
    end

    // A reset on the commit edge must suppress the RAM side effects too.
    assign ram_we = commit && c_wr && c_is_ram && !Reset;
    assign ram_re = commit && !c_wr && c_is_ram && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            data_q  <= 16'h0000;
            wr_q    <= 1'b0;
            hex_q   <= 16'h0000;
            sw_q    <= 16'h0000;
            src_q   <= SRC_ZERO;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            hex_q   <= hex_d;
            sw_q    <= sw_d;
            src_q   <= src_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (ram_we) ram[ram_idx] <= c_data;
        if (ram_re) ram_rd_q <= ram[ram_idx];
    end

    always_comb begin
        MDR_In = 16'h0000;
        unique case (src_q)
            SRC_SW:  MDR_In = sw_q;
            SRC_RAM: MDR_In = ram_rd_q;
            default: MDR_In = 16'h0000;
        endcase
    end

    assign R       = (state_q == S_RESP);
    assign HEX_Out = hex_q;
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the SLC-3 datapath's MAR/MDR memory interface.
- Accepts read/write requests addressed by MAR, with write data from MDR.
- Services requests from an internal word RAM, or from a memory-mapped I/O location, after a configurable wait-state count.
- Returns read data on MDR_In and signals completion with a one-cycle ready pulse R; the control unit holds its memory state until R is seen.

Parameters:
ADDR_BITS, 10, RAM depth is 2**ADDR_BITS 16-bit words, mapped at addresses 0 .. 2**ADDR_BITS-1
WAIT_CYCLES, 2, wait states inserted between request capture and response (0..15)
IO_ADDR, 16'hFFFF, address of the memory-mapped I/O location

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-high reset
MAR  input  16  request address from datapath
MDR  input  16  write data from datapath
Mem_RD  input  1  read request, level, held by requester until R
Mem_WR  input  1  write request, level, held by requester until R
Switches  input  16  value returned on reads of IO_ADDR
MDR_In  output  16  read data to datapath MDR mux
R  output  1  response pulse, high exactly one cycle per transaction
HEX_Out  output  16  last value written to IO_ADDR

Behaviour:
- One clock; reset is synchronous and active-high. On a clock edge with Reset=1: state=IDLE, R=0, MDR_In=16'h0000, HEX_Out=16'h0000, wait counter=0. RAM contents are not affected by reset.
- States: IDLE, WAIT, RESP, DONE.
- IDLE:
  - If Mem_RD or Mem_WR is high at an edge, capture MAR, MDR and the operation into internal registers.
  - If both are high, write takes priority; the transaction is a write only.
  - Next state is WAIT with counter loaded to WAIT_CYCLES, or RESP directly if WAIT_CYCLES=0.
- WAIT: decrement the counter each cycle; on the edge where the counter is 1, go to RESP.
- Entering RESP, on the edge leaving IDLE or WAIT, the operation commits:
  - Write to a RAM address: RAM[addr] <= data.
  - Write to IO_ADDR: HEX_Out <= data.
  - Write to any other address: ignored.
  - Read from a RAM address: MDR_In <= RAM[addr].
  - Read from IO_ADDR: MDR_In <= Switches, sampled at that edge.
  - Read from any other address: MDR_In <= 16'h0000.
- RESP: R=1 for this single cycle. Next state is DONE.
- DONE: R=0. Stay in DONE until Mem_RD=0 and Mem_WR=0 at an edge, then go to IDLE. A request held high after R is never serviced twice.
- Latency:
  - R is high in the cycle WAIT_CYCLES+1 clocks after the capturing edge.
  - MDR_In is valid in the same cycle R is high.
  - Minimum spacing between capturing edges is WAIT_CYCLES+3 cycles.
- Request changes after the capture edge (MAR, MDR, or the operation) do not affect the in-flight transaction.
- MDR_In holds its value until the next read commits; writes never change MDR_In.
- Reset in WAIT aborts the transaction: no RAM or HEX_Out update and no R pulse. Reset in RESP or DONE returns the block to IDLE.
- Address decode: an address is a RAM address when MAR[15:ADDR_BITS]==0. IO_ADDR takes precedence if it would otherwise fall in RAM.

Test Plan:
- Write then read back, WAIT_CYCLES=2: write 16'hBEEF to 16'h0010, drop request after R, then read 16'h0010. Required: R high 3 cycles after each capture edge; MDR_In=16'hBEEF in the R cycle.
- Held request: hold Mem_RD=1 for 20 cycles at 16'h0004. Required: exactly one R pulse; no second capture until Mem_RD=0.
- I/O: write 16'h1234 to 16'hFFFF. Required: HEX_Out=16'h1234 after R. Then, with Switches=16'h00A5, read 16'hFFFF. Required: MDR_In=16'h00A5.
- Out-of-range: write 16'h5555 to 16'h0800 (ADDR_BITS=10), then read 16'h0800. Required: MDR_In=16'h0000, and RAM[0] unchanged.
- Simultaneous Mem_RD=Mem_WR=1 writing 16'h0F0F to 16'h0002. Required: write performed, MDR_In unchanged; a subsequent read of 16'h0002 returns 16'h0F0F.
- Reset mid-op: assert Reset one cycle into WAIT of a write of 16'hDEAD to 16'h0003. Required: no R pulse, outputs at reset values, and RAM[3] keeps its prior value (16'h0000 if pre-written so).
